univ_shift_reg: RTL and testbench

- N-bit universal shift register. Successor to the team's free-running serial shift register.
- Adds an enable, parallel load/clear, left/right/rotate/arithmetic modes and a counted burst mode with busy/done status.
- Serves as the shift core behind the serializer/deserializer and bit-manipulation datapaths.
- With op=SHR and en=1 held continuously, it is a free-running right shifter (serial in at MSB, serial out at LSB).

---
 rtl/univ_shift_reg.sv | 116 +++++++++++
 tb/tb_univ_shift_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: direct ops (hold, shift, rotate, arithmetic
// shift, load, clear) plus a counted burst mode reporting busy/done.
module univ_shift_reg #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [N-1:0]  d_in,
    input  logic          s_in_l,
    input  logic          s_in_r,
    input  logic          start,
    input  logic [CW-1:0] cnt,
    output logic [N-1:0]  q,
    output logic          s_out_r,
    output logic          s_out_l,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ASR  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_reg;
    logic [2:0]      op_reg;
    logic [CW-1:0]   rem_reg;
    logic [N-1:0]    q_reg;
    logic            busy_reg;
    logic            done_reg;

    logic [2:0]      eff_op;
    logic [N-1:0]    q_next;
    logic            start_ok;

    // A burst runs the latched op; otherwise the live op select drives the datapath.
    always_comb begin
        eff_op = (state_reg == BURST) ? op_reg : op;
        q_next = q_reg;
        case (eff_op)
            OP_HOLD: q_next = q_reg;
            OP_SHR:  q_next = {s_in_l, q_reg[N-1:1]};
            OP_SHL:  q_next = {q_reg[N-2:0], s_in_r};
            OP_ROR:  q_next = {q_reg[0], q_reg[N-1:1]};
            OP_ROL:  q_next = {q_reg[N-2:0], q_reg[N-1]};
            OP_ASR:  q_next = {q_reg[N-1], q_reg[N-1:1]};
            OP_LOAD: q_next = d_in;
            OP_CLR:  q_next = '0;
            default: q_next = q_reg;
        endcase
        // Only the shifting/rotating ops can be burst; start with other ops is ignored.
        start_ok = start && (op >= OP_SHR) && (op <= OP_ASR);
    end

    // Register, burst sequencing and status; start is taken in IDLE regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_HOLD;
            rem_reg   <= '0;
            q_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        if (cnt == '0) begin
                            // Empty burst: report completion without touching q.
                            done_reg <= 1'b1;
                        end else begin
                            op_reg    <= op;
                            rem_reg   <= cnt;
                            busy_reg  <= 1'b1;
                            state_reg <= BURST;
                        end
                    end else if (en) begin
                        q_reg <= q_next;
                    end
                end
                BURST: begin
                    if (en) begin
                        q_reg   <= q_next;
                        rem_reg <= rem_reg - 1'b1;
                        if (rem_reg == CW'(1)) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign q       = q_reg;
    assign s_out_r = q_reg[0];
    assign s_out_l = q_reg[N-1];
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic, checked
// every cycle against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [N-1:0]  d_in = '0;
    logic          s_in_l = 1'b0;
    logic          s_in_r = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic [N-1:0]  q;
    logic          s_out_r;
    logic          s_out_l;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Directed literal expectations consumed by the compare process.
    logic          lit_en = 1'b0;
    logic [N-1:0]  lit_q = '0;
    logic          lit_busy = 1'b0;
    logic          lit_done = 1'b0;

    // Reference model state.
    logic [N-1:0]  m_q = '0;
    logic          m_done = 1'b0;
    int            m_left = 0;
    logic [2:0]    m_op = 3'd0;
    logic          m_busy;

    univ_shift_reg #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .d_in(d_in),
        .s_in_l(s_in_l), .s_in_r(s_in_r), .start(start), .cnt(cnt),
        .q(q), .s_out_r(s_out_r), .s_out_l(s_out_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Next register value from the op definitions, using plain integer arithmetic.
    function automatic logic [N-1:0] apply_op(input logic [2:0] o, input logic [N-1:0] v,
                                              input logic sl, input logic sr,
                                              input logic [N-1:0] d);
        int unsigned x, top, mask, r;
        x    = v;
        top  = 1 << (N - 1);
        mask = (1 << N) - 1;
        case (o)
            3'd1:    r = (x / 2) + (sl ? top : 0);
            3'd2:    r = ((x * 2) & mask) + (sr ? 1 : 0);
            3'd3:    r = (x / 2) + (((x % 2) == 1) ? top : 0);
            3'd4:    r = ((x * 2) & mask) + ((x >= top) ? 1 : 0);
            3'd5:    r = (x / 2) + ((x >= top) ? top : 0);
            3'd6:    r = d;
            3'd7:    r = 0;
            default: r = x;
        endcase
        return N'(r);
    endfunction

    assign m_busy = (m_left > 0);

    // Model: a burst is simply "shifts still owed"; idle applies the live op.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= '0;
            m_done <= 1'b0;
            m_left <= 0;
            m_op   <= 3'd0;
        end else if (m_left > 0) begin
            if (en) begin
                m_q    <= apply_op(m_op, m_q, s_in_l, s_in_r, d_in);
                m_left <= m_left - 1;
                m_done <= (m_left == 1);
            end else begin
                m_done <= 1'b0;
            end
        end else if (start && (op inside {[3'd1:3'd5]})) begin
            if (cnt == 0) begin
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
                m_op   <= op;
                m_left <= int'(cnt);
            end
        end else begin
            m_done <= 1'b0;
            if (en) m_q <= apply_op(op, m_q, s_in_l, s_in_r, d_in);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: DUT against model every cycle, plus literal pins when posted.
    always @(negedge clk) begin
        chk("q", int'(q), int'(m_q));
        chk("s_out_r", int'(s_out_r), int'(m_q[0]));
        chk("s_out_l", int'(s_out_l), int'(m_q[N-1]));
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        if (lit_en) begin
            chk("lit_q", int'(q), int'(lit_q));
            chk("lit_model_q", int'(m_q), int'(lit_q));
            chk("lit_busy", int'(busy), int'(lit_busy));
            chk("lit_done", int'(done), int'(lit_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        lit_en = 1'b0;
    endtask

    task automatic expect_lit(input logic [N-1:0] eq, input logic eb, input logic ed);
        lit_q    = eq;
        lit_busy = eb;
        lit_done = ed;
        lit_en   = 1'b1;
    endtask

    task automatic direct(input logic [2:0] o, input logic [N-1:0] eq);
        op = o;
        tick();
        expect_lit(eq, 1'b0, 1'b0);
    endtask

    logic [N-1:0] shr_exp [8];

    initial begin
        shr_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        // Reset state.
        repeat (2) tick();
        expect_lit(8'h00, 1'b0, 1'b0);

        // Free-running right shift of ones.
        rst = 1'b0; en = 1'b1; op = 3'd1; s_in_l = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_lit(shr_exp[i], 1'b0, 1'b0);
        end

        // Direct ops.
        d_in = 8'hA5; direct(3'd6, 8'hA5);
        direct(3'd4, 8'h4B);
        direct(3'd3, 8'hA5);
        direct(3'd5, 8'hD2);
        s_in_r = 1'b1; direct(3'd2, 8'hA5);
        direct(3'd7, 8'h00);
        en = 1'b0; d_in = 8'h3C; direct(3'd6, 8'h00);

        // Burst SHL x3.
        en = 1'b1; s_in_r = 1'b0; d_in = 8'h81; direct(3'd6, 8'h81);
        op = 3'd2; cnt = 4'd3; start = 1'b1; tick(); expect_lit(8'h81, 1'b1, 1'b0);
        start = 1'b0; op = 3'd0;
        tick(); expect_lit(8'h02, 1'b1, 1'b0);
        tick(); expect_lit(8'h04, 1'b1, 1'b0);
        tick(); expect_lit(8'h08, 1'b0, 1'b1);
        tick(); expect_lit(8'h08, 1'b0, 1'b0);

        // Same burst with en stalls and an ignored mid-burst start.
        direct(3'd6, 8'h81);
        op = 3'd2; cnt = 4'd3; start = 1'b1; tick(); expect_lit(8'h81, 1'b1, 1'b0);
        start = 1'b0; op = 3'd0;
        tick(); expect_lit(8'h02, 1'b1, 1'b0);
        en = 1'b0; tick(); expect_lit(8'h02, 1'b1, 1'b0);
        start = 1'b1; op = 3'd1; cnt = 4'd7; tick(); expect_lit(8'h02, 1'b1, 1'b0);
        start = 1'b0; op = 3'd0; en = 1'b1;
        tick(); expect_lit(8'h04, 1'b1, 1'b0);
        tick(); expect_lit(8'h08, 1'b0, 1'b1);
        tick(); expect_lit(8'h08, 1'b0, 1'b0);

        // Zero-length burst, then start with a non-shift op.
        d_in = 8'h5A; direct(3'd6, 8'h5A);
        op = 3'd1; cnt = 4'd0; start = 1'b1; tick(); expect_lit(8'h5A, 1'b0, 1'b1);
        op = 3'd6; d_in = 8'h33; tick(); expect_lit(8'h33, 1'b0, 1'b0);
        start = 1'b0;

        // ROR burst longer than N.
        d_in = 8'h01; direct(3'd6, 8'h01);
        op = 3'd3; cnt = 4'd10; start = 1'b1; tick(); expect_lit(8'h01, 1'b1, 1'b0);
        start = 1'b0; op = 3'd0;
        repeat (9) tick();
        tick(); expect_lit(8'h40, 1'b0, 1'b1);
        tick(); expect_lit(8'h40, 1'b0, 1'b0);

        // Same burst, reset asynchronously after the 4th shift.
        direct(3'd6, 8'h01);
        op = 3'd3; cnt = 4'd10; start = 1'b1; tick();
        start = 1'b0; op = 3'd0;
        repeat (4) tick();
        rst = 1'b1; expect_lit(8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick(); expect_lit(8'h00, 1'b0, 1'b0);
        tick(); expect_lit(8'h00, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            en     = ($urandom_range(0, 3) != 0);
            op     = 3'($urandom_range(0, 7));
            start  = ($urandom_range(0, 5) == 0);
            cnt    = CW'($urandom_range(0, 15));
            d_in   = N'($urandom);
            s_in_l = 1'($urandom);
            s_in_r = 1'($urandom);
            tick();
        end

        rst = 1'b0; start = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
